// File: rtl/instr_loader_pkg.sv
// Shared types and helpers for the streaming instruction-memory loader.
// Also used by the assembler-side helpers that compute the trailer word.
package instr_loader_pkg;

    localparam int D_DEF = 12;
    localparam int W_DEF = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // One step of the running XOR checksum over program words.
    function automatic logic [W_DEF-1:0] csum_step(input logic [W_DEF-1:0] acc,
                                                   input logic [W_DEF-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Purpose: streams len words into instruction memory at 0.., checks an XOR trailer, releases cpu_hold.
// Latency: start->in_ready 1 cycle; transfer->wr_en 1 cycle; trailer->done/err 1 cycle.
// Backpressure: in_ready high only in LOAD/CHECK; no buffering, unaccepted words are ignored.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D:0]   load_len,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold
);

    localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};
    localparam logic [D:0] ONE     = (D+1)'(1);

    state_t       state;
    logic [D:0]   len;
    logic [D:0]   cnt;
    logic [W-1:0] csum;
    logic         xfer;

    // Status flags depend on the state register alone, never on inputs.
    assign in_ready = (state == LOAD) || (state == CHECK);
    assign busy     = (state == LOAD) || (state == CHECK);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            len     <= '0;
            cnt     <= '0;
            csum    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        len  <= load_len;
                        cnt  <= '0;
                        csum <= '0;
                        if (load_len == '0)
                            state <= DONE;
                        else if (load_len > MAX_LEN)
                            state <= ERR;
                        else
                            state <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[D-1:0];
                        wr_data <= in_data;
                        csum    <= csum_step(csum, in_data);
                        cnt     <= cnt + ONE;
                        if (cnt == len - ONE)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    // The trailer is compared only, never written to memory.
                    if (xfer)
                        state <= (in_data == csum) ? DONE : ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard fed by the stimulus.
module tb_instr_loader;
    localparam int D = 12;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset, start, in_valid;
    logic [D:0]   load_len;
    logic [W-1:0] in_data;
    logic         in_ready, wr_en, busy, done, err, cpu_hold;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;

    typedef struct packed {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          mon_e;
    int           total = 0;
    int           bad = 0;
    int           wr_count = 0;
    logic [D-1:0] last_addr = '0;

    instr_loader #(.D(D), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            last_addr = wr_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {20'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {20'd0, wr_addr}, {20'd0, mon_e.a});
                check("wr_data", {23'd0, wr_data}, {23'd0, mon_e.d});
            end
        end
    end

    task automatic do_start(input logic [D:0] len);
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [D-1:0] a, input bit push, input bit stall);
        bit  accepted = 1'b0;
        int  guard = 0;
        wr_t w;
        while (!accepted && guard < 40) begin
            guard++;
            if (stall && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                accepted = in_ready;
                if (accepted && push) begin
                    w.a = a;
                    w.d = d;
                    exp_q.push_back(w);
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!accepted) check("xfer_timeout_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"},    {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_addr"},  {20'd0, wr_addr}, 32'd0);
        check({tag, "_wr_data"},  {23'd0, wr_data}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check({tag, "_done"},     {31'd0, done}, 32'd0);
        check({tag, "_err"},      {31'd0, err}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] cs;
        logic [W-1:0] words[5];
        int           w0;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; load_len = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Nominal three-word load.
        w0 = wr_count;
        do_start(13'd3);
        check("nom_in_ready", {31'd0, in_ready}, 32'd1);
        check("nom_busy", {31'd0, busy}, 32'd1);
        send(9'h0FE, 12'd0, 1'b1, 1'b0);
        send(9'h0CC, 12'd1, 1'b1, 1'b0);
        send(9'h0F4, 12'd2, 1'b1, 1'b0);
        send(9'h0C6, 12'd0, 1'b0, 1'b0);
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("nom_busy_after", {31'd0, busy}, 32'd0);
        check("nom_writes", wr_count - w0, 32'd3);
        check("nom_queue_empty", exp_q.size(), 32'd0);

        // Bad checksum, then retry from ERR.
        w0 = wr_count;
        do_start(13'd3);
        check("rearm_done", {31'd0, done}, 32'd0);
        check("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send(9'h0FE, 12'd0, 1'b1, 1'b0);
        send(9'h0CC, 12'd1, 1'b1, 1'b0);
        send(9'h0F4, 12'd2, 1'b1, 1'b0);
        send(9'h000, 12'd0, 1'b0, 1'b0);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("bad_writes", wr_count - w0, 32'd3);
        do_start(13'd3);
        send(9'h0FE, 12'd0, 1'b1, 1'b0);
        send(9'h0CC, 12'd1, 1'b1, 1'b0);
        send(9'h0F4, 12'd2, 1'b1, 1'b0);
        send(9'h0C6, 12'd0, 1'b0, 1'b0);
        check("retry_done", {31'd0, done}, 32'd1);

        // Illegal length 4097.
        w0 = wr_count;
        do_start(13'd4097);
        check("len4097_err", {31'd0, err}, 32'd1);
        check("len4097_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 9'h055;
        repeat (3) @(negedge clk);
        check("len4097_in_ready_later", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check("len4097_no_write", wr_count - w0, 32'd0);

        // Zero length from ERR.
        w0 = wr_count;
        do_start(13'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("len0_no_write", wr_count - w0, 32'd0);

        // Full-depth load of 4096 words.
        w0 = wr_count;
        cs = '0;
        do_start(13'd4096);
        for (int i = 0; i < 4096; i++) begin
            d  = W'($urandom);
            cs = cs ^ d;
            send(d, D'(i), 1'b1, 1'b0);
        end
        @(negedge clk);
        check("full_in_check_busy", {31'd0, busy}, 32'd1);
        check("full_last_addr", {20'd0, last_addr}, 32'd4095);
        check("full_writes", wr_count - w0, 32'd4096);
        send(cs, 12'd0, 1'b0, 1'b0);
        check("full_done", {31'd0, done}, 32'd1);

        // Randomly stalled five-word load.
        w0 = wr_count;
        cs = '0;
        do_start(13'd5);
        for (int i = 0; i < 5; i++) begin
            words[i] = W'($urandom);
            cs = cs ^ words[i];
            send(words[i], D'(i), 1'b1, 1'b1);
        end
        send(cs, 12'd0, 1'b0, 1'b1);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_writes", wr_count - w0, 32'd5);
        check("stall_queue_empty", exp_q.size(), 32'd0);

        // start during LOAD must not disturb the sequence.
        w0 = wr_count;
        cs = '0;
        do_start(13'd5);
        for (int i = 0; i < 5; i++) begin
            words[i] = W'($urandom);
            cs = cs ^ words[i];
        end
        send(words[0], 12'd0, 1'b1, 1'b0);
        send(words[1], 12'd1, 1'b1, 1'b0);
        start    = 1'b1;
        load_len = 13'd1;
        @(negedge clk);
        start    = 1'b0;
        check("ign_start_busy", {31'd0, busy}, 32'd1);
        for (int i = 2; i < 5; i++) send(words[i], D'(i), 1'b1, 1'b0);
        send(cs, 12'd0, 1'b0, 1'b0);
        check("ign_start_done", {31'd0, done}, 32'd1);
        check("ign_start_writes", wr_count - w0, 32'd5);

        // Reset after two of five words.
        do_start(13'd5);
        send(9'h111, 12'd0, 1'b1, 1'b0);
        send(9'h022, 12'd1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        check("midreset_queue_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        do_start(13'd2);
        send(9'h1A5, 12'd0, 1'b1, 1'b0);
        send(9'h05A, 12'd1, 1'b1, 1'b0);
        send(9'h1FF, 12'd0, 1'b0, 1'b0);
        check("post_reset_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
